// File: rtl/arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package arb_pkg;

  typedef logic [31:0] word;
  typedef word instr_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    ERROR  = 2'd3
  } arb_state_t;

  localparam logic [3:0] FETCH_BE = 4'b1111;

endpackage

// File: rtl/arb_watchdog.sv
// Response watchdog: counts enabled cycles since the last clear and flags the
// cycle whose increment would reach TimeoutCycles. TimeoutCycles = 0 disables it.
module arb_watchdog
  import arb_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic clk,
  input  logic res,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam bit          ENABLED = (TimeoutCycles != 0);
  localparam logic [15:0] LAST    = 16'(TimeoutCycles - 1);

  logic [15:0] count;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && ENABLED) begin
      count <= count + 16'd1;
    end
  end

  // Expiry is flagged during the last allowed cycle so the FSM can still let a
  // response arriving in that same cycle win over the error transition.
  assign expired = ENABLED && enable && (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the instruction-fetch and data ports onto one memory port, with
// data priority, a fetch starvation guard and a response watchdog.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MaxDataBurst  = 4,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic        clk,
  input  logic        res,
  input  logic        instr_req,
  input  word         instr_addr,
  output instr_t      instr_read,
  output logic        instr_valid,
  input  logic        data_req,
  input  word         data_addr,
  input  logic        data_write_enable,
  input  logic [3:0]  data_be,
  input  word         data_write,
  output word         data_read,
  output logic        data_valid,
  output logic        mem_req,
  output word         mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output word         mem_wdata,
  input  word         mem_rdata,
  input  logic        mem_valid,
  output logic        busy,
  output logic        err
);

  localparam logic [3:0] BURST_LIMIT = 4'(MaxDataBurst);

  arb_state_t state, state_next;
  logic       grant_i, grant_d;
  logic       in_busy;
  logic       wd_expired;
  logic [3:0] streak;

  always_ff @(posedge clk or negedge res) begin
    if (!res) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        // Data wins unless fetches have been passed over MaxDataBurst times.
        if (data_req && !(instr_req && (streak == BURST_LIMIT))) begin
          grant_d    = 1'b1;
          state_next = BUSY_D;
        end else if (instr_req) begin
          grant_i    = 1'b1;
          state_next = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_valid)       state_next = IDLE;
        else if (wd_expired) state_next = ERROR;
      end
      ERROR:   state_next = ERROR;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_busy     = (state == BUSY_I) || (state == BUSY_D);
    mem_req     = in_busy;
    busy        = in_busy;
    err         = (state == ERROR);
    instr_valid = mem_valid && (state == BUSY_I);
    data_valid  = mem_valid && (state == BUSY_D);
    instr_read  = (state == BUSY_I) ? mem_rdata : '0;
    data_read   = (state == BUSY_D) ? mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      streak <= '0;
    end else if (grant_d && instr_req) begin
      streak <= streak + 4'd1;
    end else if (grant_d || grant_i) begin
      streak <= '0;
    end
  end

  // Downstream request fields only move on a grant edge.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else if (grant_d) begin
      mem_addr  <= data_addr;
      mem_we    <= data_write_enable;
      mem_be    <= data_be;
      mem_wdata <= data_write;
    end else if (grant_i) begin
      mem_addr  <= instr_addr;
      mem_we    <= 1'b0;
      mem_be    <= FETCH_BE;
      mem_wdata <= '0;
    end
  end

  arb_watchdog #(
    .TimeoutCycles(TimeoutCycles)
  ) u_watchdog (
    .clk    (clk),
    .res    (res),
    .clear  (grant_i || grant_d),
    .enable (in_busy && !mem_valid),
    .expired(wd_expired)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter and the stand-alone watchdog.
module tb_mem_arbiter;
  import arb_pkg::*;

  logic        clk;
  logic        res;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic [31:0] instr_read;
  logic        instr_valid;
  logic        data_req;
  logic [31:0] data_addr;
  logic        data_write_enable;
  logic [3:0]  data_be;
  logic [31:0] data_write;
  logic [31:0] data_read;
  logic        data_valid;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        busy;
  logic        err;
  logic        wd_clear;
  logic        wd_enable;
  logic        wd_expired;

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(
    .MaxDataBurst (4),
    .TimeoutCycles(8)
  ) dut (
    .clk              (clk),
    .res              (res),
    .instr_req        (instr_req),
    .instr_addr       (instr_addr),
    .instr_read       (instr_read),
    .instr_valid      (instr_valid),
    .data_req         (data_req),
    .data_addr        (data_addr),
    .data_write_enable(data_write_enable),
    .data_be          (data_be),
    .data_write       (data_write),
    .data_read        (data_read),
    .data_valid       (data_valid),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_we           (mem_we),
    .mem_be           (mem_be),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .mem_valid        (mem_valid),
    .busy             (busy),
    .err              (err)
  );

  arb_watchdog #(
    .TimeoutCycles(0)
  ) wd_off (
    .clk    (clk),
    .res    (res),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    res = 1'b0;
    instr_req = 0; instr_addr = 0; data_req = 0; data_addr = 0;
    data_write_enable = 0; data_be = 0; data_write = 0;
    mem_rdata = 0; mem_valid = 0; wd_clear = 0; wd_enable = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({mem_req, mem_addr, mem_we, mem_be, mem_wdata, busy, err,
         instr_valid, data_valid, instr_read, data_read} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got req=%b addr=%h we=%b be=%h wdata=%h busy=%b err=%b iv=%b dv=%b required all zero",
               mem_req, mem_addr, mem_we, mem_be, mem_wdata, busy, err, instr_valid, data_valid);
    end
    res = 1'b1;
    step();
    // A spurious response in IDLE must not produce any valid.
    mem_valid = 1; mem_rdata = 32'hCAFE0000;
    #1;
    checks++;
    if ({instr_valid, data_valid, mem_req, busy} !== 4'b0000) begin
      failures++;
      $display("FAIL idle_spurious got iv=%b dv=%b req=%b busy=%b required 0000",
               instr_valid, data_valid, mem_req, busy);
    end
    step();
    mem_valid = 0;
  endtask

  task automatic test_single_fetch();
    instr_req = 1; instr_addr = 32'h100;
    step();
    checks++;
    if ({mem_req, busy, mem_addr, mem_be, mem_we} !== {1'b1, 1'b1, 32'h100, 4'hF, 1'b0}) begin
      failures++;
      $display("FAIL fetch_request got req=%b busy=%b addr=%h be=%h we=%b required 1 1 00000100 f 0",
               mem_req, busy, mem_addr, mem_be, mem_we);
    end
    mem_valid = 1; mem_rdata = 32'h00500093;
    #1;
    checks++;
    if (instr_valid !== 1'b1 || instr_read !== 32'h00500093) begin
      failures++;
      $display("FAIL fetch_response got valid=%b read=%h required 1 00500093", instr_valid, instr_read);
    end
    checks++;
    if (data_valid !== 1'b0) begin
      failures++;
      $display("FAIL fetch_data_silent got data_valid=%b required 0", data_valid);
    end
    step();
    instr_req = 0; mem_valid = 0;
    #1;
    checks++;
    if ({mem_req, busy, instr_valid} !== 3'b000) begin
      failures++;
      $display("FAIL fetch_done got req=%b busy=%b iv=%b required 000", mem_req, busy, instr_valid);
    end
  endtask

  task automatic test_simultaneous();
    data_req = 1; data_addr = 32'h200; data_write_enable = 1; data_be = 4'b0011;
    data_write = 32'hDEADBEEF;
    instr_req = 1; instr_addr = 32'h300;
    step();
    checks++;
    if ({mem_req, mem_addr, mem_we, mem_be, mem_wdata} !== {1'b1, 32'h200, 1'b1, 4'b0011, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL simul_data_first got req=%b addr=%h we=%b be=%h wdata=%h required 1 00000200 1 3 deadbeef",
               mem_req, mem_addr, mem_we, mem_be, mem_wdata);
    end
    mem_valid = 1; mem_rdata = 32'h0;
    #1;
    checks++;
    if (data_valid !== 1'b1 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL simul_write_ack got dv=%b iv=%b required 1 0", data_valid, instr_valid);
    end
    step();
    data_req = 0; data_write_enable = 0; mem_valid = 0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL simul_idle_gap got req=%b required 0", mem_req);
    end
    step();
    checks++;
    if ({mem_req, mem_addr, mem_we, mem_be} !== {1'b1, 32'h300, 1'b0, 4'hF}) begin
      failures++;
      $display("FAIL simul_fetch_next got req=%b addr=%h we=%b be=%h required 1 00000300 0 f",
               mem_req, mem_addr, mem_we, mem_be);
    end
    mem_valid = 1; mem_rdata = 32'h11112222;
    #1;
    checks++;
    if (instr_valid !== 1'b1 || instr_read !== 32'h11112222) begin
      failures++;
      $display("FAIL simul_fetch_resp got valid=%b read=%h required 1 11112222", instr_valid, instr_read);
    end
    step();
    instr_req = 0; mem_valid = 0;
  endtask

  task automatic test_starvation();
    logic [31:0] exp_addr [6];
    exp_addr[0] = 32'h400; exp_addr[1] = 32'h400; exp_addr[2] = 32'h400;
    exp_addr[3] = 32'h400; exp_addr[4] = 32'h500; exp_addr[5] = 32'h400;
    data_req = 1; data_addr = 32'h400; data_write_enable = 0; data_be = 4'hF;
    instr_req = 1; instr_addr = 32'h500;
    mem_valid = 1; mem_rdata = 32'h55AA55AA;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== exp_addr[k]) begin
        failures++;
        $display("FAIL starve_grant%0d got req=%b addr=%h required 1 %h", k, mem_req, mem_addr, exp_addr[k]);
      end
      checks++;
      if (instr_valid !== (exp_addr[k] == 32'h500) || data_valid !== (exp_addr[k] == 32'h400)) begin
        failures++;
        $display("FAIL starve_valid%0d got iv=%b dv=%b", k, instr_valid, data_valid);
      end
      step();
    end
    data_req = 0; instr_req = 0; mem_valid = 0;
    step();
  endtask

  task automatic test_wait_states();
    data_req = 1; data_addr = 32'h600; data_write_enable = 0; data_be = 4'b1100;
    step();
    for (int c = 0; c < 6; c++) begin
      if (c == 5) begin
        mem_valid = 1; mem_rdata = 32'h12345678;
      end
      #1;
      checks++;
      if ({mem_req, busy, mem_addr, mem_we, mem_be} !== {1'b1, 1'b1, 32'h600, 1'b0, 4'b1100}) begin
        failures++;
        $display("FAIL wait_hold%0d got req=%b busy=%b addr=%h we=%b be=%h required 1 1 00000600 0 c",
                 c, mem_req, busy, mem_addr, mem_we, mem_be);
      end
      checks++;
      if (data_valid !== (c == 5)) begin
        failures++;
        $display("FAIL wait_valid%0d got dv=%b required %b", c, data_valid, (c == 5));
      end
      step();
    end
    data_req = 0; mem_valid = 0;
    #1;
    checks++;
    if ({busy, mem_req, data_valid} !== 3'b000) begin
      failures++;
      $display("FAIL wait_done got busy=%b req=%b dv=%b required 000", busy, mem_req, data_valid);
    end
    checks++;
    if (data_read !== 32'h0) begin
      failures++;
      $display("FAIL wait_read_idle got read=%h required 00000000", data_read);
    end
  endtask

  task automatic test_watchdog();
    instr_req = 1; instr_addr = 32'h700;
    step();
    for (int c = 1; c <= 8; c++) begin
      #1;
      checks++;
      if (busy !== 1'b1 || err !== 1'b0) begin
        failures++;
        $display("FAIL wd_busy%0d got busy=%b err=%b required 1 0", c, busy, err);
      end
      step();
    end
    checks++;
    if ({err, mem_req, busy} !== 3'b100) begin
      failures++;
      $display("FAIL wd_error got err=%b req=%b busy=%b required 1 0 0", err, mem_req, busy);
    end
    data_req = 1; data_addr = 32'h780; mem_valid = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({err, mem_req, instr_valid, data_valid} !== 4'b1000) begin
        failures++;
        $display("FAIL wd_sticky%0d got err=%b req=%b iv=%b dv=%b required 1 0 0 0",
                 c, err, mem_req, instr_valid, data_valid);
      end
    end
    res = 0;
    #1;
    checks++;
    if (err !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL wd_reset_clears got err=%b req=%b required 0 0", err, mem_req);
    end
    instr_req = 0; data_req = 0; mem_valid = 0;
    step();
    res = 1;
    step();
  endtask

  task automatic test_reset_mid_transaction();
    data_req = 1; data_addr = 32'h900; data_write_enable = 1; data_be = 4'hF; data_write = 32'h1;
    step();
    checks++;
    if (mem_req !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_busy got req=%b busy=%b required 1 1", mem_req, busy);
    end
    #2;
    res = 0;
    #1;
    checks++;
    if ({mem_req, busy, mem_addr, mem_we} !== {1'b0, 1'b0, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL midrst_async got req=%b busy=%b addr=%h we=%b required 0 0 00000000 0",
               mem_req, busy, mem_addr, mem_we);
    end
    data_req = 0; data_write_enable = 0;
    step();
    res = 1;
    step();
    instr_req = 1; instr_addr = 32'h800;
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h800 || mem_be !== 4'hF) begin
      failures++;
      $display("FAIL midrst_fetch got req=%b addr=%h be=%h required 1 00000800 f", mem_req, mem_addr, mem_be);
    end
    mem_valid = 1; mem_rdata = 32'h0BADF00D;
    #1;
    checks++;
    if (instr_valid !== 1'b1 || instr_read !== 32'h0BADF00D) begin
      failures++;
      $display("FAIL midrst_fetch_resp got valid=%b read=%h required 1 0badf00d", instr_valid, instr_read);
    end
    step();
    instr_req = 0; mem_valid = 0;
  endtask

  task automatic test_watchdog_disabled();
    wd_clear = 1; wd_enable = 0;
    step();
    wd_clear = 0; wd_enable = 1;
    for (int c = 0; c < 40; c++) begin
      #1;
      checks++;
      if (wd_expired !== 1'b0) begin
        failures++;
        $display("FAIL wd_disabled%0d got expired=%b required 0", c, wd_expired);
      end
      step();
    end
    wd_enable = 0;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_wait_states();
    test_watchdog();
    test_reset_mid_transaction();
    test_watchdog_disabled();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
